vending_machine_multi: RTL and testbench

VENDING_MACHINE_MULTI -- requirements
Module: vending_machine_multi

---
 rtl/vending_machine_multi.sv | 196 +++++++++++++++++++
 tb/tb_vending_machine_multi.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/vending_machine_multi.sv
// Multi-product vending machine: coin accumulation, priced selection with per-product stock,
// greedy change return, cancel and inactivity auto-refund.
module vending_machine_multi #(
    parameter int unsigned                NUM_PROD   = 4,
    parameter int unsigned                CREDIT_W   = 8,
    parameter logic [NUM_PROD*8-1:0]      PRICES     = {8'd7, 8'd5, 8'd3, 8'd2},
    parameter int unsigned                STOCK_W    = 4,
    parameter int unsigned                STOCK_INIT = 5,
    parameter int unsigned                TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          coin_in,
    input  logic [NUM_PROD-1:0] sel,
    input  logic                cancel,
    input  logic                restock,
    output logic [NUM_PROD-1:0] vend,
    output logic [2:0]          chg_coin,
    output logic                coin_rej,
    output logic                err,
    output logic [CREDIT_W-1:0] credit,
    output logic [NUM_PROD-1:0] sold_out,
    output logic                busy
);

    localparam int unsigned IDX_W = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CNT_W-1:0]    idle_q, idle_d;
    logic [IDX_W-1:0]    vidx_q, vidx_d;
    logic [STOCK_W-1:0]  stock_q [NUM_PROD];
    logic [STOCK_W-1:0]  stock_d [NUM_PROD];
    logic [NUM_PROD-1:0] vend_q, vend_d;
    logic [2:0]          chg_q, chg_d;
    logic                rej_q, rej_d;
    logic                err_q, err_d;

    logic [2:0]          coin_val;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_ok;
    logic                coin_fits;
    logic [IDX_W-1:0]    sel_idx;
    logic                sel_one;
    logic                sel_valid;
    logic [7:0]          sel_price;
    logic [7:0]          vend_price;
    logic [CREDIT_W-1:0] remainder;
    logic [2:0]          chg_val;
    logic [CNT_W-1:0]    idle_inc;
    logic                activity;

    always_comb begin
        coin_val = 3'd0;
        case (coin_in)
            3'b001:  coin_val = 3'd1;
            3'b010:  coin_val = 3'd2;
            3'b100:  coin_val = 3'd5;
            default: coin_val = 3'd0;
        endcase
        coin_ok   = (coin_val != 3'd0);
        coin_sum  = {1'b0, credit_q} + {{(CREDIT_W - 2){1'b0}}, coin_val};
        coin_fits = !coin_sum[CREDIT_W];

        sel_idx = '0;
        for (int i = 0; i < NUM_PROD; i++) begin
            if (sel[i]) sel_idx = IDX_W'(i);
        end
        sel_one   = (sel != '0) && ((sel & (sel - NUM_PROD'(1))) == '0);
        sel_price = PRICES[sel_idx*8 +: 8];
        // Judged against credit before any coin arriving in the same cycle.
        sel_valid = sel_one && (stock_q[sel_idx] != '0) &&
                    ((CREDIT_W + 8)'(credit_q) >= (CREDIT_W + 8)'(sel_price));

        vend_price = PRICES[vidx_q*8 +: 8];
        remainder  = credit_q - CREDIT_W'(vend_price);

        if (credit_q >= CREDIT_W'(5))      chg_val = 3'd5;
        else if (credit_q >= CREDIT_W'(2)) chg_val = 3'd2;
        else                               chg_val = 3'd1;

        activity = coin_ok || (sel != '0) || cancel;
        idle_inc = idle_q + CNT_W'(1);
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        idle_d   = idle_q;
        vidx_d   = vidx_q;
        stock_d  = stock_q;
        vend_d   = '0;
        chg_d    = 3'b000;
        rej_d    = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (coin_ok) begin
                    if (coin_fits) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                        state_d  = CREDIT;
                        idle_d   = '0;
                    end else begin
                        rej_d = 1'b1;
                    end
                end
                if (sel != '0) err_d = 1'b1;
            end
            CREDIT: begin
                idle_d = activity ? '0 : idle_inc;
                if (coin_ok) begin
                    if (coin_fits) credit_d = coin_sum[CREDIT_W-1:0];
                    else           rej_d = 1'b1;
                end
                if (cancel) begin
                    state_d = CHANGE;
                    idle_d  = '0;
                end else if (sel != '0) begin
                    if (sel_valid) begin
                        state_d = VEND;
                        vidx_d  = sel_idx;
                        vend_d  = NUM_PROD'(1) << sel_idx;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (!activity && idle_inc == TIMEOUT_C) begin
                    state_d = CHANGE;
                    idle_d  = '0;
                end
            end
            VEND: begin
                rej_d            = coin_ok;
                credit_d         = remainder;
                stock_d[vidx_q]  = stock_q[vidx_q] - STOCK_W'(1);
                state_d          = (remainder != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                rej_d = coin_ok;
                if (credit_q == '0) begin
                    state_d = IDLE;
                end else begin
                    chg_d    = (chg_val == 3'd5) ? 3'b100 : (chg_val == 3'd2) ? 3'b010 : 3'b001;
                    credit_d = credit_q - CREDIT_W'(chg_val);
                    if (credit_q == CREDIT_W'(chg_val)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Reload wins over a same-cycle vend decrement.
        if (restock) begin
            for (int i = 0; i < NUM_PROD; i++) stock_d[i] = STOCK_W'(STOCK_INIT);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            credit_q <= '0;
            idle_q   <= '0;
            vidx_q   <= '0;
            vend_q   <= '0;
            chg_q    <= 3'b000;
            rej_q    <= 1'b0;
            err_q    <= 1'b0;
            for (int i = 0; i < NUM_PROD; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            idle_q   <= idle_d;
            vidx_q   <= vidx_d;
            vend_q   <= vend_d;
            chg_q    <= chg_d;
            rej_q    <= rej_d;
            err_q    <= err_d;
            stock_q  <= stock_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PROD; i++) sold_out[i] = (stock_q[i] == '0);
    end

    assign vend     = vend_q;
    assign chg_coin = chg_q;
    assign coin_rej = rej_q;
    assign err      = err_q;
    assign credit   = credit_q;
    assign busy     = (state_q == VEND) || (state_q == CHANGE);

endmodule

// File: tb/tb_vending_machine_multi.sv
// Directed bench for vending_machine_multi; dispense and change pulses are checked in order
// against a queue of expected events.
module tb_vending_machine_multi;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] coin_in = 3'b000;
    logic [3:0] sel = 4'b0000;
    logic       cancel = 1'b0;
    logic       restock = 1'b0;
    logic [3:0] vend;
    logic [2:0] chg_coin;
    logic       coin_rej;
    logic       err;
    logic [7:0] credit;
    logic [3:0] sold_out;
    logic       busy;

    int total = 0;
    int bad = 0;
    int exp_q[$];  // 100+vend for dispense events, chg_coin value for change coins

    vending_machine_multi dut (
        .clk      (clk),
        .reset    (reset),
        .coin_in  (coin_in),
        .sel      (sel),
        .cancel   (cancel),
        .restock  (restock),
        .vend     (vend),
        .chg_coin (chg_coin),
        .coin_rej (coin_rej),
        .err      (err),
        .credit   (credit),
        .sold_out (sold_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Scoreboard: every dispense or change pulse must match the next queued event.
    always @(negedge clk) begin
        if (!reset && (vend != 4'b0000 || chg_coin != 3'b000)) begin
            int obs;
            int expv;
            obs  = (vend != 4'b0000) ? 100 + int'(vend) : int'(chg_coin);
            expv = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            chk("event", obs, expv);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_coin(input logic [2:0] c);
        coin_in = c;
        tick();
        coin_in = 3'b000;
    endtask

    task automatic press(input logic [3:0] s);
        sel = s;
        tick();
        sel = 4'b0000;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
        if (busy) chk({tag, "_idle_timeout"}, 1, 0);
        tick();
    endtask

    initial begin
        int n;

        tick();
        tick();
        chk("rst_credit", int'(credit), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sold_out", int'(sold_out), 0);
        chk("rst_vend", int'(vend), 0);
        reset = 1'b0;
        tick();

        // Selection with no credit and a non-one-hot coin
        press(4'b0001);
        chk("idle_sel_err", int'(err), 1);
        put_coin(3'b011);
        chk("bad_coin_credit", int'(credit), 0);
        chk("bad_coin_rej", int'(coin_rej), 0);

        // 2+5, buy product 1 (price 3), change 2,2
        put_coin(3'b010);
        put_coin(3'b100);
        chk("credit_7", int'(credit), 7);
        exp_q.push_back(102);
        exp_q.push_back(2);
        exp_q.push_back(2);
        press(4'b0010);
        chk("vend_latency", int'(vend), 4'b0010);
        chk("busy_in_vend", int'(busy), 1);
        wait_idle("buy1", 10);
        chk("buy1_credit", int'(credit), 0);
        chk("buy1_queue", exp_q.size(), 0);

        // Insufficient credit for product 3
        put_coin(3'b010);
        press(4'b1000);
        chk("poor_err", int'(err), 1);
        chk("poor_credit", int'(credit), 2);
        chk("poor_vend", int'(vend), 0);
        exp_q.push_back(2);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        wait_idle("poor", 10);
        chk("poor_refund_credit", int'(credit), 0);

        // Drain product 0, then sold-out error and restock
        for (int i = 0; i < 5; i++) begin
            put_coin(3'b010);
            exp_q.push_back(101);
            press(4'b0001);
            wait_idle("drain", 10);
        end
        chk("sold_out0", int'(sold_out), 4'b0001);
        put_coin(3'b010);
        press(4'b0001);
        chk("sold_out_err", int'(err), 1);
        chk("sold_out_credit", int'(credit), 2);
        exp_q.push_back(2);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        wait_idle("sold", 10);
        restock = 1'b1;
        tick();
        restock = 1'b0;
        chk("restocked", int'(sold_out), 0);

        // Overflow rejection near full credit
        for (int i = 0; i < 50; i++) put_coin(3'b100);
        put_coin(3'b010);
        chk("credit_252", int'(credit), 252);
        put_coin(3'b100);
        chk("ovf_rej", int'(coin_rej), 1);
        chk("ovf_credit", int'(credit), 252);
        put_coin(3'b010);
        chk("fill_rej", int'(coin_rej), 0);
        chk("credit_254", int'(credit), 254);
        for (int i = 0; i < 50; i++) exp_q.push_back(4);
        exp_q.push_back(2);
        exp_q.push_back(2);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        put_coin(3'b001);
        chk("change_coin_rej", int'(coin_rej), 1);
        wait_idle("big", 80);
        chk("big_credit", int'(credit), 0);
        chk("big_queue", exp_q.size(), 0);

        // Inactivity refund of 8
        put_coin(3'b100);
        put_coin(3'b010);
        put_coin(3'b001);
        chk("credit_8", int'(credit), 8);
        exp_q.push_back(4);
        exp_q.push_back(2);
        exp_q.push_back(1);
        n = 0;
        while (!busy && n < 400) begin
            tick();
            n++;
        end
        total++;
        assert (n >= 254 && n <= 256) else begin
            bad++;
            $error("FAIL timeout_cycles observed=%0d expected=255", n);
        end
        wait_idle("timeout", 10);
        chk("timeout_credit", int'(credit), 0);
        chk("timeout_queue", exp_q.size(), 0);

        // Cancel beats a valid selection; reset aborts change midway
        put_coin(3'b100);
        put_coin(3'b001);
        exp_q.push_back(4);
        sel = 4'b0001;
        cancel = 1'b1;
        tick();
        sel = 4'b0000;
        cancel = 1'b0;
        chk("cancel_wins_vend", int'(vend), 0);
        chk("cancel_busy", int'(busy), 1);
        tick();
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_credit", int'(credit), 0);
        chk("abort_chg", int'(chg_coin), 0);
        chk("abort_busy", int'(busy), 0);
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("abort_credit_after", int'(credit), 0);
        chk("final_queue", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
